// File: rtl/nrd_sequencer.sv
// Control sequencer for the non-restoring divider: bgn/done handshake, iteration counter, strobes c0..c8.
// Optional divide-by-zero abort is enabled with `define DIVZ_CHECK_EN (adds m_zero input, err output).
module nrd_sequencer #(
   parameter int N     = 8,
   parameter int CNT_W = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             bgn,
   input  logic             s,
`ifdef DIVZ_CHECK_EN
   input  logic             m_zero,
   output logic             err,
`endif
   output logic             c0,
   output logic             c1,
   output logic             c2,
   output logic             c3,
   output logic             c4,
   output logic             c5,
   output logic             c6,
   output logic             c7,
   output logic             c8,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] cnt
);

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      LOAD_Q  = 4'd1,
      LOAD_M  = 4'd2,
      SHIFT   = 4'd3,
      ADDSUB  = 4'd4,
      SETQ    = 4'd5,
      CORRECT = 4'd6,
      OUT_A   = 4'd7,
      OUT_Q   = 4'd8,
      DONE    = 4'd9
   } state_e;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [8:0]       strb_q;
   logic             busy_q, done_q;
   logic             abort_now;

`ifdef DIVZ_CHECK_EN
   logic             err_q;
   // M is loaded on the edge into SHIFT, so the zero test can only be made in SHIFT itself.
   assign abort_now = (state_q == SHIFT) && (cnt_q == '0) && m_zero;
   assign err       = err_q;
`else
   assign abort_now = 1'b0;
`endif

   // State-only strobes, bit k drives ck.
   function automatic logic [8:0] decode(input state_e st);
      logic [8:0] v;
      v = '0;
      case (st)
         LOAD_Q:  v = 9'b0_0000_0011;
         LOAD_M:  v = 9'b0_0000_0100;
         SHIFT:   v = 9'b0_0010_0000;
         ADDSUB:  v = 9'b0_0000_1000;
         SETQ:    v = 9'b0_0100_0000;
         OUT_A:   v = 9'b1_0000_0000;
         OUT_Q:   v = 9'b0_1000_0000;
         default: v = '0;
      endcase
      return v;
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE:    if (bgn) state_d = LOAD_Q;
         LOAD_Q:  begin
            cnt_d   = '0;
            state_d = LOAD_M;
         end
         LOAD_M:  state_d = SHIFT;
         SHIFT:   state_d = abort_now ? DONE : ADDSUB;
         ADDSUB:  state_d = SETQ;
         SETQ:    begin
            cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
            state_d = (cnt_q == LAST) ? CORRECT : SHIFT;
         end
         CORRECT: state_d = OUT_A;
         OUT_A:   state_d = OUT_Q;
         OUT_Q:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they belong to.
   always_ff @(posedge clk) begin
      if (rst_b) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         strb_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef DIVZ_CHECK_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         strb_q  <= decode(state_d);
         busy_q  <= (state_d != IDLE);
         done_q  <= (state_d == DONE);
`ifdef DIVZ_CHECK_EN
         err_q   <= abort_now;
`endif
      end
   end

   // s is the live sign of {S,A}: pre-load in ADDSUB, final remainder sign in CORRECT.
   assign c0   = strb_q[0];
   assign c1   = strb_q[1];
   assign c2   = strb_q[2];
   assign c3   = strb_q[3] | ((state_q == CORRECT) & s);
   assign c4   = strb_q[4] | ((state_q == ADDSUB) & ~s);
   assign c5   = strb_q[5] & ~abort_now;
   assign c6   = strb_q[6];
   assign c7   = strb_q[7];
   assign c8   = strb_q[8];
   assign busy = busy_q;
   assign done = done_q;
   assign cnt  = cnt_q;

   a_outbus_excl: assert property (@(posedge clk) disable iff (rst_b) !(c7 && c8));
   a_load_shift:  assert property (@(posedge clk) disable iff (rst_b) !(c3 && c5));
   a_done_busy:   assert property (@(posedge clk) disable iff (rst_b) done |-> busy);

endmodule

// File: tb/tb_nrd_sequencer.sv
// Bench for nrd_sequencer: behavioural A/Q/M/S datapath plus a per-cycle expected trace built from
// plain integer non-restoring division arithmetic.
module tb_nrd_sequencer;
  localparam int N     = 8;
  localparam int CNT_W = 3;
  localparam int W     = 23;
  localparam logic [8:0] C0 = 9'h001, C1 = 9'h002, C2 = 9'h004, C3 = 9'h008, C4 = 9'h010;
  localparam logic [8:0] C5 = 9'h020, C6 = 9'h040, C7 = 9'h080, C8 = 9'h100;

  typedef struct {
    int a;
    int b;
    int exp_qt;
    int exp_rm;
    int exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_b, bgn, s;
  logic c0, c1, c2, c3, c4, c5, c6, c7, c8, busy, done;
  logic [CNT_W-1:0] cnt;
`ifdef DIVZ_CHECK_EN
  logic m_zero, err;
`else
  logic err;
  assign err = 1'b0;
`endif

  logic [N:0]   sa;
  logic [N-1:0] q_r, m_r, op_a, op_b, outbus;

  int checks = 0, errors = 0, cyc = 0, done_cnt = 0;
  int q_cap, a_cap;
  logic in_idle = 1'b0;
  logic [W-1:0] exp_q[$];

  nrd_sequencer #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_b(rst_b), .bgn(bgn), .s(s),
`ifdef DIVZ_CHECK_EN
    .m_zero(m_zero), .err(err),
`endif
    .c0(c0), .c1(c1), .c2(c2), .c3(c3), .c4(c4), .c5(c5), .c6(c6), .c7(c7), .c8(c8),
    .busy(busy), .done(done), .cnt(cnt)
  );

  always #5 clk = ~clk;

  // ---------------- datapath model ----------------
  always @(posedge clk) begin
    if (rst_b) begin
      sa  <= '0;
      q_r <= '0;
      m_r <= '0;
    end else begin
      if (c0) sa <= '0;
      if (c1) q_r <= op_a;
      if (c2) m_r <= op_b;
      if (c3) sa <= c4 ? sa - {1'b0, m_r} : sa + {1'b0, m_r};
      if (c5) {sa, q_r} <= {sa[N-1:0], q_r, 1'b0};
      if (c6) q_r[0] <= ~sa[N];
    end
  end

  assign s      = sa[N];
  assign outbus = c7 ? q_r : (c8 ? sa[N-1:0] : '0);
`ifdef DIVZ_CHECK_EN
  assign m_zero = (m_r == '0);
`endif

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ent(input logic b_, input logic d_, input logic e_,
                                       input logic [8:0] c_, input int n_, input int v_);
    return {b_, d_, e_, c_, n_[CNT_W-1:0], v_[7:0]};
  endfunction

  function automatic void push_trace(input int a, input int b);
    int r;
    exp_q.push_back(ent(1, 0, 0, C0 | C1, 0, 0));
    exp_q.push_back(ent(1, 0, 0, C2, 0, 0));
`ifdef DIVZ_CHECK_EN
    if (b == 0) begin
      exp_q.push_back(ent(1, 0, 0, 9'h000, 0, 0));
      exp_q.push_back(ent(1, 1, 1, 9'h000, 0, 0));
      return;
    end
`endif
    r = 0;
    for (int i = 0; i < N; i++) begin
      r = 2 * r + ((a >> (N - 1 - i)) & 1);
      exp_q.push_back(ent(1, 0, 0, C5, i, 0));
      if (r < 0) begin
        exp_q.push_back(ent(1, 0, 0, C3, i, 0));
        r = r + b;
      end else begin
        exp_q.push_back(ent(1, 0, 0, C3 | C4, i, 0));
        r = r - b;
      end
      exp_q.push_back(ent(1, 0, 0, C6, i, 0));
    end
    exp_q.push_back(ent(1, 0, 0, (r < 0) ? C3 : 9'h000, 0, 0));
    exp_q.push_back(ent(1, 0, 0, C8, 0, a % b));
    exp_q.push_back(ent(1, 0, 0, C7, 0, a / b));
    exp_q.push_back(ent(1, 1, 0, 9'h000, 0, 0));
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic check_cycle();
    logic [W-1:0] e, act;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      in_idle = 1'b0;
    end else begin
      e = '0;
      in_idle = 1'b1;
    end
    act = {busy, done, err, c8, c7, c6, c5, c4, c3, c2, c1, c0, cnt, outbus};
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL cycle_%0d act=%h exp=%h", cyc, act, e);
    end
    if (c8) a_cap = int'(outbus);
    if (c7) q_cap = int'(outbus);
    if (done) done_cnt++;
  endtask

  // One clock: model reacts to the sampled inputs, outputs checked at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst_b) exp_q.delete();
    else if (in_idle && bgn) push_trace(int'(op_a), int'(op_b));
    @(negedge clk);
    check_cycle();
    #1;
  endtask

  // ---------------- driver ----------------
  task automatic run_op(input int a, input int b, input int eq, input int er,
                        input int elat, input int eerr, input string nm);
    int lat;
    int err_seen;
    bit got;
    op_a = 8'(a);
    op_b = 8'(b);
    q_cap = -1;
    a_cap = -1;
    err_seen = 0;
    lat = 0;
    got = 0;
    bgn = 1'b1;
    while (!got && lat < 100) begin
      tick();
      lat++;
      if (lat == 1) bgn = 1'b0;
      if (done) begin
        got = 1;
        err_seen = int'(err);
      end
    end
    chk({nm, "_lat"}, got ? lat : -1, elat);
    if (elat > 4) begin
      chk({nm, "_q"}, q_cap, eq);
      chk({nm, "_r"}, a_cap, er);
    end
    chk({nm, "_err"}, err_seen, eerr);
    tick();
  endtask

  initial begin
    vec_t vecs[7];
    int d0;
    int dt[$];
    int ra, rb;

    vecs[0] = '{100, 7, 14, 2, 30};
    vecs[1] = '{255, 1, 255, 0, 30};
    vecs[2] = '{13, 5, 2, 3, 30};
    vecs[3] = '{0, 9, 0, 0, 30};
    vecs[4] = '{127, 127, 1, 0, 30};
    vecs[5] = '{200, 3, 66, 2, 30};
    vecs[6] = '{1, 100, 0, 1, 30};

    rst_b = 1'b1;
    bgn   = 1'b0;
    op_a  = '0;
    op_b  = 8'd1;
    repeat (3) tick();
    chk("reset_busy", int'(busy), 0);
    chk("reset_cnt", int'(cnt), 0);
    chk("reset_strb", int'({c8, c7, c6, c5, c4, c3, c2, c1, c0}), 0);
    rst_b = 1'b0;
    tick();

    for (int i = 0; i < 7; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp_qt, vecs[i].exp_rm, vecs[i].exp_lat, 0, $sformatf("vec%0d", i));

    // bgn pulses while busy are ignored
    d0 = done_cnt;
    op_a = 8'd100;
    op_b = 8'd7;
    q_cap = -1;
    bgn = 1'b1;
    for (int lat = 1; lat <= 45; lat++) begin
      tick();
      if (lat == 1 || lat == 6 || lat == 13) bgn = 1'b0;
      if (lat == 5 || lat == 12) bgn = 1'b1;
    end
    chk("ignore_done_count", done_cnt - d0, 1);
    chk("ignore_q", q_cap, 14);

    // synchronous reset in the middle of an operation
    bgn = 1'b1;
    for (int lat = 1; lat <= 15; lat++) begin
      tick();
      if (lat == 1) bgn = 1'b0;
    end
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_cnt", int'(cnt), 0);
    chk("midrst_strb", int'({c8, c7, c6, c5, c4, c3, c2, c1, c0}), 0);
    run_op(100, 7, 14, 2, 30, 0, "after_rst");

    // bgn held high: back-to-back operations with one IDLE cycle between
    bgn = 1'b1;
    for (int lat = 1; lat <= 75; lat++) begin
      tick();
      if (lat == 40) bgn = 1'b0;
      if (done) dt.push_back(lat);
    end
    chk("held_done_count", dt.size(), 2);
    if (dt.size() == 2) begin
      chk("held_first_done", dt[0], 30);
      chk("held_spacing", dt[1] - dt[0], 31);
    end

`ifdef DIVZ_CHECK_EN
    run_op(20, 0, 0, 0, 4, 1, "divz");
    run_op(9, 3, 3, 0, 30, 0, "after_divz");
`endif

    for (int k = 0; k < 25; k++) begin
      ra = int'($urandom_range(0, 255));
      rb = int'($urandom_range(1, 127));
      run_op(ra, rb, ra / rb, ra % rb, 30, 0, $sformatf("rnd%0d", k));
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
